// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like slave port between the inst and data masters
// One transaction is outstanding at a time, and the FSM runs IDLE -> ADDR -> DATA.
// The winner's wr/size/addr/wdata are latched in IDLE and held on m_* until the next grant.
// The grant register gnt records the last winner: 0 means inst and 1 means data.
// Ports:
//   clk, rst      core clock; asynchronous active-low reset
//   inst_*        instruction master: req/wr/size/addr/wdata in, rdata/addr_ok/data_ok out
//   data_*        data master, with the same port set as the instruction master
//   m_*           slave side: req/wr/size/addr/wdata out, rdata/addr_ok/data_ok in
// Build option ARB_ROUND_ROBIN_EN: when both masters request together, the master that was
//   not granted last wins. Without it the data master always has priority.
module sram_like_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state;
  logic   gnt;
  logic   pick_data;
  logic   a_ok;
  logic   d_ok;
`ifdef ARB_ROUND_ROBIN_EN
  // gnt=0 means inst won last, so data gets the next tie; a lone requester always wins
  assign pick_data = data_req & (~inst_req | ~gnt);
`else
  assign pick_data = data_req;
`endif
  assign m_req = state == ADDR;
  assign a_ok  = m_req & m_addr_ok;
  // data_ok counts only once the slave has accepted the address, which can be the same cycle
  assign d_ok  = (a_ok | state == DATA) & m_data_ok;
  assign inst_addr_ok = a_ok & ~gnt;
  assign data_addr_ok = a_ok & gnt;
  assign inst_data_ok = d_ok & ~gnt;
  assign data_data_ok = d_ok & gnt;
  assign inst_rdata   = inst_data_ok ? m_rdata : '0;
  assign data_rdata   = data_data_ok ? m_rdata : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      m_wr    <= 1'b0;
      m_size  <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (inst_req | data_req) begin
          gnt     <= pick_data;
          m_wr    <= pick_data ? data_wr    : inst_wr;
          m_size  <= pick_data ? data_size  : inst_size;
          m_addr  <= pick_data ? data_addr  : inst_addr;
          m_wdata <= pick_data ? data_wdata : inst_wdata;
          state   <= ADDR;
        end
        ADDR: if (m_addr_ok) state <= m_data_ok ? IDLE : DATA;
        DATA: if (m_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed self-checking bench for sram_like_arbiter
module tb_sram_like_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, m_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata, data_addr, data_wdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int          total = 0;
  int          passed = 0;
  logic        rr;
  logic        exp_data;

  always #5 clk = ~clk;

  sram_like_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rst = 1'b0;
    {inst_req, inst_wr, inst_size, inst_addr, inst_wdata} = '0;
    {data_req, data_wr, data_size, data_addr, data_wdata} = '0;
    {m_addr_ok, m_data_ok, m_rdata} = '0;
    #1;
    chk("rst_m_req", m_req, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    tick(); rst = 1'b1; #1;
    chk("rel_m_req0", m_req, 0);
    tick(); #1;
    chk("rel_m_req1", m_req, 0);
    // reset in the middle of ADDR
    tick(); inst_req = 1'b1; inst_addr = 32'hBFC00000; inst_size = 2'b10; #1;
    tick(); #1;
    chk("mid_m_req", m_req, 1);
    chk("mid_m_addr", m_addr, 32'hBFC00000);
    m_addr_ok = 1'b1; m_data_ok = 1'b1; rst = 1'b0; #1;
    chk("mid_rst_m_req", m_req, 0);
    chk("mid_rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    chk("mid_rst_m_addr", m_addr, 0);
    tick(); inst_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0; rst = 1'b1; #1;
    chk("post_rst_m_req0", m_req, 0);
    tick(); #1;
    chk("post_rst_m_req1", m_req, 0);
    // inst-only read
    tick(); inst_req = 1'b1; inst_wr = 1'b0; inst_addr = 32'hBFC00000; #1;
    chk("rd_c0_m_req", m_req, 0);
    tick(); #1;
    chk("rd_c1_m_req", m_req, 1);
    chk("rd_c1_m_addr", m_addr, 32'hBFC00000);
    chk("rd_c1_m_wr", m_wr, 0);
    chk("rd_c1_addr_ok", inst_addr_ok, 0);
    tick(); m_addr_ok = 1'b1; #1;
    chk("rd_c2_inst_addr_ok", inst_addr_ok, 1);
    chk("rd_c2_data_addr_ok", data_addr_ok, 0);
    chk("rd_c2_inst_data_ok", inst_data_ok, 0);
    tick(); inst_req = 1'b0; m_addr_ok = 1'b0; #1;
    chk("rd_c3_m_req", m_req, 0);
    chk("rd_c3_inst_addr_ok", inst_addr_ok, 0);
    tick(); m_data_ok = 1'b1; m_rdata = 32'h3C1D0000; #1;
    chk("rd_c4_inst_data_ok", inst_data_ok, 1);
    chk("rd_c4_inst_rdata", inst_rdata, 32'h3C1D0000);
    chk("rd_c4_data_side", {data_addr_ok, data_data_ok, data_rdata}, 0);
    tick(); m_data_ok = 1'b0; #1;
    chk("rd_c5_inst_rdata", inst_rdata, 0);
    chk("rd_c5_m_req", m_req, 0);
    tick(); m_data_ok = 1'b1; #1;
    chk("idle_data_ok_ign", {inst_data_ok, data_data_ok, inst_rdata}, 0);
    // simultaneous requests with a zero-wait slave
    tick(); m_data_ok = 1'b0;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'b10; data_addr = 32'h80001000;
    data_wdata = 32'hDEADBEEF;
    inst_req = 1'b1; inst_addr = 32'hBFC00004; #1;
    tick(); #1;
    chk("both_m_req", m_req, 1);
    chk("both_m_wr", m_wr, 1);
    chk("both_m_addr", m_addr, 32'h80001000);
    chk("both_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("both_m_size", m_size, 2);
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h11111111; #1;
    chk("both_data_oks", {data_addr_ok, data_data_ok}, 2'b11);
    chk("both_inst_quiet", {inst_addr_ok, inst_data_ok, inst_rdata}, 0);
    tick(); data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0; #1;
    chk("bubble_m_req", m_req, 0);
    chk("bubble_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    tick(); #1;
    chk("inst2_m_req", m_req, 1);
    chk("inst2_m_addr", m_addr, 32'hBFC00004);
    chk("inst2_m_wr", m_wr, 0);
    m_addr_ok = 1'b1; #1;
    chk("inst2_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b10);
    tick(); inst_req = 1'b0; m_addr_ok = 1'b0; #1;
    chk("inst2_data_m_req", m_req, 0);
    m_data_ok = 1'b1; m_rdata = 32'h24080001; #1;
    chk("inst2_data_ok", inst_data_ok, 1);
    chk("inst2_rdata", inst_rdata, 32'h24080001);
    tick(); m_data_ok = 1'b0; #1;
    chk("inst2_done_m_req", m_req, 0);
    // both masters held for four transactions
    tick(); inst_req = 1'b1; inst_addr = 32'h100; data_req = 1'b1; data_wr = 1'b0;
    data_addr = 32'h200; #1;
    for (int k = 0; k < 4; k++) begin
      exp_data = rr ? (k % 2 == 0) : 1'b1;
      tick(); #1;
      chk("hold_m_req", m_req, 1);
      chk("hold_m_addr", m_addr, exp_data ? 32'h200 : 32'h100);
      m_addr_ok = 1'b1; m_data_ok = 1'b1; #1;
      chk("hold_data_grant", {data_addr_ok, data_data_ok}, {exp_data, exp_data});
      chk("hold_inst_grant", {inst_addr_ok, inst_data_ok}, {!exp_data, !exp_data});
      tick(); m_addr_ok = 1'b0; m_data_ok = 1'b0;
      if (k == 3) begin
        inst_req = 1'b0;
        data_req = 1'b0;
      end
      #1;
      chk("hold_bubble", m_req, 0);
    end
    // slave stalls addr_ok; latched request must stay stable
    tick(); data_req = 1'b1; data_wr = 1'b1; data_size = 2'b01; data_addr = 32'h12345678;
    data_wdata = 32'hCAFEF00D; #1;
    tick(); data_req = 1'b0; data_addr = 32'h0; data_wdata = 32'h0; m_data_ok = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_m_req", m_req, 1);
      chk("stall_m_addr", m_addr, 32'h12345678);
      chk("stall_m_wdata", m_wdata, 32'hCAFEF00D);
      chk("stall_m_size", m_size, 1);
      chk("stall_oks", {data_addr_ok, data_data_ok}, 0);
      tick(); #1;
    end
    m_data_ok = 1'b0; m_addr_ok = 1'b1; #1;
    chk("stall_addr_ok", {data_addr_ok, data_data_ok, inst_addr_ok}, 3'b100);
    tick(); m_addr_ok = 1'b0; #1;
    chk("stall_data_m_req", m_req, 0);
    m_data_ok = 1'b1; m_rdata = 32'h5A5A5A5A; #1;
    chk("stall_data_ok", data_data_ok, 1);
    chk("stall_rdata", data_rdata, 32'h5A5A5A5A);
    chk("stall_inst_quiet", {inst_data_ok, inst_rdata}, 0);
    tick(); m_data_ok = 1'b0; #1;
    chk("stall_done", {m_req, data_data_ok, data_rdata}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
